wakeup_broadcast: RTL
=====================

Name: wakeup_broadcast

Overview:
- Producer side of the rename-stage wakeup interface (wakeup_active / wakeup_tag / wakeup_value).
- Collects completed results from NUM_SRC functional units through valid/ready handshakes and buffers them in an in-order FIFO.
- Broadcasts at most one physical-register wakeup per cycle to rename and the issue queues.
- Sits between execute/writeback and rename; replaces the constant-zero wakeup tie-off.

Parameters:
- TAG_W, 6, physical register tag width (64 physical regs).
- DATA_W, 32, result value width.
- NUM_SRC, 3, number of completing functional units (ALU0, ALU1, LSU).
- DEPTH, 8, FIFO entries; must be a power of two and at least NUM_SRC.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- flush  in  1  synchronous flush; drops all buffered and pending wakeups.
- src_valid  in  NUM_SRC  per-source result valid.
- src_tag  in  NUM_SRC*TAG_W  per-source destination tag; source i occupies bits [i*TAG_W +: TAG_W].
- src_value  in  NUM_SRC*DATA_W  per-source result; source i occupies bits [i*DATA_W +: DATA_W].
- src_ready  out  NUM_SRC  per-source accept; all bits always equal.
- wakeup_active  out  1  broadcast valid, high for exactly one cycle per wakeup.
- wakeup_tag  out  TAG_W  broadcast tag.
- wakeup_value  out  DATA_W  broadcast value.
- occupancy  out  $clog2(DEPTH)+1  current FIFO entry count.

Behaviour:
- Reset (reset=0, async):
  - FIFO pointers, occupancy, wakeup_active, wakeup_tag and wakeup_value all go to 0.
  - src_ready is forced to 0 while reset is low.
- Ready rule:
  - src_ready = all ones when DEPTH - occupancy >= NUM_SRC, else all zeros.
  - Decoded from registered occupancy only; there is no combinational path from src_valid to src_ready.
- Accept:
  - At a rising edge where src_ready=1, every source with src_valid=1 is written into the FIFO in ascending source index (lowest index nearest the head).
  - 0 to NUM_SRC writes per cycle.
- Tag 0 filter: a valid source with tag 0 is handshaked (consumed) but never enqueued; p0 is hardwired and needs no wakeup.
- Pop and broadcast:
  - At each edge where occupancy > 0 before the edge, the head entry is popped into the output register and wakeup_active=1 for the following cycle.
  - Otherwise wakeup_active=0.
  - wakeup_tag and wakeup_value hold their last value when inactive.
- Latency: an entry accepted at edge N into an empty FIFO is broadcast in the cycle after edge N+1 (2 cycles). There is no bypass.
- Same-edge push and pop: pop uses the pre-edge head.
  - occupancy_next = occupancy + writes - pop.
- Ordering: wakeups leave in strict acceptance order; across sources in the same cycle, lower index goes first.
- Wrap-around: read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full and empty are decided only from occupancy.
- Full: with occupancy > DEPTH-NUM_SRC, ready drops. Pops continue, so ready returns once occupancy <= DEPTH-NUM_SRC. Overflow is impossible by construction.
- Flush (priority over everything):
  - At an edge with flush=1: occupancy and both pointers go to 0, wakeup_active goes to 0 next cycle, and any sources handshaked that edge are discarded.
  - src_ready is unaffected by flush itself.
- Reset mid-operation: all state clears immediately, including an in-flight wakeup_active.
- Occupancy changes only at clock edges (or async reset); it never glitches combinationally.

Test Plan:
- Reset, then single source 0: valid with tag=5, value=0x0000_00AA at edge 1 -> wakeup_active=1, tag=5, value=0xAA during cycle after edge 2 only; occupancy reads 1 after edge 1 and 0 after edge 2.
- Simultaneous accept: sources 0,1,2 valid with tags 3,7,9 in one cycle -> three consecutive broadcast cycles with tags 3, 7, 9 in that order; peak occupancy 3.
- Full backpressure: all three sources valid every cycle with DEPTH=8 -> src_ready=0 once occupancy>5; no tag lost or duplicated over 20 cycles; ready re-asserts when occupancy<=5; pointers wrap at least twice.
- Tag 0 filter: source 1 valid with tag 0, source 2 valid with tag 12 -> single broadcast of tag 12; occupancy peaks at 1.
- Flush: occupancy=4, flush=1 together with src 0 valid tag 20 -> occupancy=0 and wakeup_active=0 next cycle; tag 20 never broadcast.
- Async reset mid-broadcast: drive reset=0 between edges while wakeup_active=1 -> wakeup_active, occupancy and src_ready go to 0 immediately without a clock edge.

Source files
------------

// File: rtl/wakeup_broadcast_if.sv
// Wakeup broadcast bundle: completion handshakes from the functional units
// plus the single-lane wakeup broadcast and occupancy seen by rename.
interface wakeup_broadcast_if #(
  parameter int TAG_W   = 6,
  parameter int DATA_W  = 32,
  parameter int NUM_SRC = 3,
  parameter int DEPTH   = 8
);
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC*TAG_W-1:0]  src_tag;
  logic [NUM_SRC*DATA_W-1:0] src_value;
  logic [NUM_SRC-1:0]        src_ready;
  logic                      wakeup_active;
  logic [TAG_W-1:0]          wakeup_tag;
  logic [DATA_W-1:0]         wakeup_value;
  logic [$clog2(DEPTH):0]    occupancy;

  modport master (
    output src_valid, src_tag, src_value,
    input  src_ready, wakeup_active, wakeup_tag, wakeup_value, occupancy
  );

  modport slave (
    input  src_valid, src_tag, src_value,
    output src_ready, wakeup_active, wakeup_tag, wakeup_value, occupancy
  );
endinterface

// File: rtl/wakeup_broadcast.sv
// Collects completed results from NUM_SRC units into an in-order FIFO and
// broadcasts one physical-register wakeup per cycle to rename/issue.
module wakeup_broadcast #(
  parameter int TAG_W   = 6,
  parameter int DATA_W  = 32,
  parameter int NUM_SRC = 3,
  parameter int DEPTH   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  wakeup_broadcast_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int unsigned READY_MAX = DEPTH - NUM_SRC;

  logic [TAG_W-1:0]  tag_mem   [DEPTH];
  logic [DATA_W-1:0] value_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [OCC_W-1:0] occ, occ_next, wr_cnt;
  logic [PTR_W-1:0] wr_addr [NUM_SRC];
  logic [NUM_SRC-1:0] wr_en;
  logic ready_int, pop;

  logic             active_q;
  logic [TAG_W-1:0] tag_q;
  logic [DATA_W-1:0] value_q;

  // Ready depends only on registered occupancy, so there is no valid->ready path.
  assign ready_int     = (occ <= OCC_W'(READY_MAX));
  assign bus.src_ready = {NUM_SRC{ready_int & reset}};
  assign pop           = (occ != '0);

  // Sources pack into consecutive slots in index order; tag 0 is consumed but skipped.
  always_comb begin
    wr_cnt = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      wr_en[i]   = ready_int & bus.src_valid[i] & ~flush
                   & (bus.src_tag[i*TAG_W +: TAG_W] != '0);
      wr_addr[i] = wr_ptr + PTR_W'(wr_cnt);
      if (wr_en[i]) wr_cnt = wr_cnt + OCC_W'(1);
    end
    occ_next = occ + wr_cnt - OCC_W'(pop);
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (wr_en[i]) begin
        tag_mem[wr_addr[i]]   <= bus.src_tag[i*TAG_W +: TAG_W];
        value_mem[wr_addr[i]] <= bus.src_value[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      active_q <= 1'b0;
      tag_q    <= '0;
      value_q  <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      active_q <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr + PTR_W'(wr_cnt);
      rd_ptr   <= rd_ptr + PTR_W'(pop);
      occ      <= occ_next;
      active_q <= pop;
      if (pop) begin
        tag_q   <= tag_mem[rd_ptr];
        value_q <= value_mem[rd_ptr];
      end
    end
  end

  assign bus.wakeup_active = active_q;
  assign bus.wakeup_tag    = tag_q;
  assign bus.wakeup_value  = value_q;
  assign bus.occupancy     = occ;
endmodule
